// File: rtl/debounce_multi_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package debounce_multi_pkg;

  localparam int DEF_TICK_CNT   = 500000;
  localparam int DEF_STABLE_N   = 4;
  localparam int DEF_LONG_TICKS = 200;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_multi_ch.sv
// One debounce channel: synchroniser, stable-sample counter, level, edge pulses, long-press hold.
module debounce_multi_ch
  import debounce_multi_pkg::*;
#(
  parameter int   STABLE_N    = DEF_STABLE_N,
  parameter int   SYNC_STAGES = 2,
  parameter int   LONG_TICKS  = DEF_LONG_TICKS,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic i,
  output logic o,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int SW = cnt_width(STABLE_N);
  localparam int HW = cnt_width(LONG_TICKS + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_N - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [SW-1:0]          stab;
  logic [HW-1:0]          hold;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= {SYNC_STAGES{RST_LEVEL}};
    else      sync <= {sync[SYNC_STAGES-2:0], i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o          <= RST_LEVEL;
      stab       <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
      if (tick) begin
        // A differing sample must persist STABLE_N consecutive ticks; any agreeing tick restarts the count.
        if (s != o) begin
          if (stab == STAB_LAST) begin
            o    <= s;
            stab <= '0;
            rise <= s;
            fall <= ~s;
          end else begin
            stab <= stab + 1'b1;
          end
        end else begin
          stab <= '0;
        end
      end
      // Hold counts ticks with o high; saturating keeps long_press to one pulse per press.
      if (!o) begin
        hold <= '0;
      end else if (tick && hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_PRE) long_press <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: one shared sample-tick prescaler feeding independent channels.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int   N_CH        = 4,
  parameter int   TICK_CNT    = DEF_TICK_CNT,
  parameter int   STABLE_N    = DEF_STABLE_N,
  parameter int   SYNC_STAGES = 2,
  parameter int   LONG_TICKS  = DEF_LONG_TICKS,
  parameter logic RST_LEVEL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i,
  output logic [N_CH-1:0] o,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  localparam int TW = cnt_width(TICK_CNT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);

  logic [TW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    debounce_multi_ch #(
      .STABLE_N   (STABLE_N),
      .SYNC_STAGES(SYNC_STAGES),
      .LONG_TICKS (LONG_TICKS),
      .RST_LEVEL  (RST_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .i         (i[k]),
      .o         (o[k]),
      .rise      (rise[k]),
      .fall      (fall[k]),
      .long_press(long_press[k])
    );
  end

endmodule
